cpu_bus_bridge: RTL and testbench
=================================

CPU_BUS_BRIDGE -- requirements
Module: cpu_bus_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning CPU data bus width.
REQ-002 SHALL have parameter ADDR_W, default 26, meaning CPU address bus width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2 (legal 2..4), meaning synchroniser depth on CPU_NCS/CPU_NWE/CPU_NRD.
REQ-004 SHALL have parameters BASE_ADDR, default 0, and ADDR_MASK, default 0, meaning decode window (match when (addr & ADDR_MASK) == BASE_ADDR).
REQ-005 SHALL have parameter RD_TIMEOUT, default 15, meaning cycles to wait for Rd_Ack.
REQ-006 SHALL have parameter TIMEOUT_DATA, default 16'hDEAD (DATA_W wide), meaning read data returned on timeout.
REQ-007 SHALL have one clock and a synchronous active-high reset: FPGA_Clock input 1 (all logic on rising edge); FPGA_Reset input 1 (synchronous, active-high).
REQ-008 CPU_NCS, CPU_NWE, CPU_NRD  input  1  asynchronous active-low chip select, write, read strobes.
REQ-009 CPU_Data  input  DATA_W  CPU write data; CPU_Addr  input  ADDR_W  CPU address.
REQ-010 Wr_Strobe  output  1  one-cycle write pulse; Wr_Addr  output  ADDR_W; Wr_Data  output  DATA_W.
REQ-011 Rd_Req  output  1  one-cycle read request; Rd_Addr  output  ADDR_W; Rd_Ack  input  1; Rd_Data  input  DATA_W.
REQ-012 CPU_Rd_Data  output  DATA_W  data presented to CPU; Data_OE  output  1  high = FPGA drives CPU data bus.
REQ-013 Err_Timeout, Err_Proto  output  1  sticky error flags; Err_Clr  input  1  clears both.

Function
REQ-014 CPU_NCS/NWE/NRD SHALL each pass through SYNC_STAGES flops plus one edge-detect flop; CPU_Data/CPU_Addr SHALL pass through a SYNC_STAGES+1 register delay line aligned so the captured sample is the last one taken with NWE low.
REQ-015 FSM states SHALL be IDLE, READ_WAIT, READ_HOLD; writes complete from IDLE without a state change.
REQ-016 Write: in IDLE, synchronised NWE rising with NCS low on the previous sample and address match SHALL drive Wr_Strobe high for exactly one cycle with Wr_Addr/Wr_Data from the delay line.
REQ-017 Write latency: counting the first edge sampling NWE high as edge 0, Wr_Strobe SHALL be high after edge SYNC_STAGES; Wr_Addr/Wr_Data SHALL hold until the next write.
REQ-018 Read start: in IDLE, synchronised NRD falling with NCS low and address match SHALL pulse Rd_Req one cycle with Rd_Addr, clear the wait counter, enter READ_WAIT.
REQ-019 READ_WAIT: Rd_Ack high SHALL latch Rd_Data into CPU_Rd_Data, set Data_OE next edge, enter READ_HOLD.
REQ-020 READ_WAIT: counter reaching RD_TIMEOUT without Rd_Ack SHALL load TIMEOUT_DATA, set Err_Timeout, set Data_OE, enter READ_HOLD; Rd_Ack on that same cycle SHALL win (no error).
REQ-021 READ_WAIT: synchronised NRD or NCS going high (abort) SHALL return to IDLE, Data_OE stays 0, no error.
REQ-022 READ_HOLD: synchronised NRD or NCS high SHALL clear Data_OE and return to IDLE on the same edge.
REQ-023 Rd_Ack outside READ_WAIT SHALL be ignored; CPU_Rd_Data holds last value.
REQ-024 Address mismatch SHALL produce no Wr_Strobe, no Rd_Req, no Data_OE.
REQ-025 Synchronised NWE and NRD both low with NCS low SHALL set Err_Proto, and any edge in that condition SHALL be ignored.
REQ-026 NWE rising edge while not in IDLE SHALL be ignored and set Err_Proto.
REQ-027 Err_Clr SHALL clear both flags; a set condition in the same cycle SHALL take priority.

Reset
REQ-028 FPGA_Reset high at a rising edge SHALL force IDLE, all sync/edge flops to 1 (inactive), Wr_Strobe=0, Rd_Req=0, Data_OE=0, Wr_Addr=0, Wr_Data=0, Rd_Addr=0, CPU_Rd_Data=0, Err_Timeout=0, Err_Proto=0, counter=0.
REQ-029 Reset mid-read SHALL drop Data_OE the following cycle; no strobe SHALL be generated from edges spanning reset release.

Verification
REQ-030 Write: NCS=0, Addr=0x0000123, Data=0xA5A5, NWE low 6 cycles then high -> single Wr_Strobe, Wr_Addr=0x0000123, Wr_Data=0xA5A5, at edge 2 after NWE high.
REQ-031 Read ack: NRD low, Rd_Ack=1 with Rd_Data=0x1234 three cycles after Rd_Req -> CPU_Rd_Data=0x1234, Data_OE=1 until NRD high, Err_Timeout=0.
REQ-032 Timeout: NRD low 30 cycles, no Rd_Ack -> after 15 wait cycles CPU_Rd_Data=0xDEAD, Data_OE=1, Err_Timeout=1; Err_Clr -> 0.
REQ-033 Abort: NRD low then high after 4 cycles, late Rd_Ack -> Data_OE never 1, CPU_Rd_Data unchanged.
REQ-034 Decode: ADDR_MASK=0x3000000, BASE_ADDR=0x1000000, write to 0x2000010 -> no Wr_Strobe; write to 0x1000010 -> Wr_Strobe.
REQ-035 Protocol: NWE and NRD low together with NCS=0 -> Err_Proto=1, no Wr_Strobe, no Rd_Req.

Source files
------------

// File: rtl/cpu_bus_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_bus_bridge_if : CPU-side strobes/bus plus back-end write/read     |
// |                     ports of the asynchronous CPU bus bridge          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface cpu_bus_bridge_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 26
);
  logic              CPU_NCS;
  logic              CPU_NWE;
  logic              CPU_NRD;
  logic [DATA_W-1:0] CPU_Data;
  logic [ADDR_W-1:0] CPU_Addr;

  logic              Wr_Strobe;
  logic [ADDR_W-1:0] Wr_Addr;
  logic [DATA_W-1:0] Wr_Data;

  logic              Rd_Req;
  logic [ADDR_W-1:0] Rd_Addr;
  logic              Rd_Ack;
  logic [DATA_W-1:0] Rd_Data;

  logic [DATA_W-1:0] CPU_Rd_Data;
  logic              Data_OE;

  logic              Err_Timeout;
  logic              Err_Proto;
  logic              Err_Clr;

  modport master (
    output CPU_NCS, CPU_NWE, CPU_NRD, CPU_Data, CPU_Addr, Rd_Ack, Rd_Data, Err_Clr,
    input  Wr_Strobe, Wr_Addr, Wr_Data, Rd_Req, Rd_Addr, CPU_Rd_Data, Data_OE,
           Err_Timeout, Err_Proto
  );

  modport slave (
    input  CPU_NCS, CPU_NWE, CPU_NRD, CPU_Data, CPU_Addr, Rd_Ack, Rd_Data, Err_Clr,
    output Wr_Strobe, Wr_Addr, Wr_Data, Rd_Req, Rd_Addr, CPU_Rd_Data, Data_OE,
           Err_Timeout, Err_Proto
  );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_bus_bridge : synchronises an asynchronous CPU bus and converts   |
// |                  its strobes into single-cycle write/read requests    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module cpu_bus_bridge #(
  parameter int                DATA_W       = 16,
  parameter int                ADDR_W       = 26,
  parameter int                SYNC_STAGES  = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_W-1:0] ADDR_MASK    = '0,
  parameter int                RD_TIMEOUT   = 15,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(16'hDEAD)
) (
  input  wire logic       FPGA_Clock,
  input  wire logic       FPGA_Reset,
  cpu_bus_bridge_if.slave bus
);

  localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    READ_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [SYNC_STAGES-1:0] r_ncs_sync, r_nwe_sync, r_nrd_sync;
  logic                  r_ncs_prev, r_nwe_prev, r_nrd_prev;
  logic [SYNC_STAGES:0]  r_flush;
  logic                  r_armed;
  logic [ADDR_W-1:0]     r_addr_dl [SYNC_STAGES+1];
  logic [DATA_W-1:0]     r_data_dl [SYNC_STAGES+1];

  logic w_ncs, w_nwe, w_nrd;
  logic w_proto, w_nwe_rise, w_nrd_fall, w_match, w_abort;
  logic w_wr_go, w_rd_go, w_proto_set, w_to_set;

  // Edges are only trusted once the chain has flushed after reset and both
  // strobes have been seen inactive, so a strobe held across reset is ignored.
  always_ff @(posedge FPGA_Clock) begin
    if (FPGA_Reset) begin
      r_ncs_sync <= '1;
      r_nwe_sync <= '1;
      r_nrd_sync <= '1;
      r_ncs_prev <= 1'b1;
      r_nwe_prev <= 1'b1;
      r_nrd_prev <= 1'b1;
      r_flush    <= '0;
      r_armed    <= 1'b0;
      for (int i = 0; i <= SYNC_STAGES; i++) begin
        r_addr_dl[i] <= '0;
        r_data_dl[i] <= '0;
      end
    end else begin
      r_ncs_sync <= {r_ncs_sync[SYNC_STAGES-2:0], bus.CPU_NCS};
      r_nwe_sync <= {r_nwe_sync[SYNC_STAGES-2:0], bus.CPU_NWE};
      r_nrd_sync <= {r_nrd_sync[SYNC_STAGES-2:0], bus.CPU_NRD};
      r_ncs_prev <= w_ncs;
      r_nwe_prev <= w_nwe;
      r_nrd_prev <= w_nrd;
      r_flush    <= {r_flush[SYNC_STAGES-1:0], 1'b1};
      if (r_flush[SYNC_STAGES] && w_nwe && w_nrd)
        r_armed <= 1'b1;
      r_addr_dl[0] <= bus.CPU_Addr;
      r_data_dl[0] <= bus.CPU_Data;
      for (int i = 1; i <= SYNC_STAGES; i++) begin
        r_addr_dl[i] <= r_addr_dl[i-1];
        r_data_dl[i] <= r_data_dl[i-1];
      end
    end
  end

  always_comb begin
    w_ncs      = r_ncs_sync[SYNC_STAGES-1];
    w_nwe      = r_nwe_sync[SYNC_STAGES-1];
    w_nrd      = r_nrd_sync[SYNC_STAGES-1];
    // Both strobes low now or on the previous sample masks the edges leaving it.
    w_proto    = (!w_ncs && !w_nwe && !w_nrd) ||
                 (!r_ncs_prev && !r_nwe_prev && !r_nrd_prev);
    w_nwe_rise = r_armed && w_nwe && !r_nwe_prev && !w_proto;
    w_nrd_fall = r_armed && !w_nrd && r_nrd_prev && !w_proto;
    w_match    = (r_addr_dl[SYNC_STAGES] & ADDR_MASK) == BASE_ADDR;
    w_abort    = w_nrd || w_ncs;
    w_wr_go    = w_nwe_rise && !r_ncs_prev && w_match && (r_state == IDLE);
    w_rd_go    = w_nrd_fall && !w_ncs && w_match && (r_state == IDLE);
    w_proto_set = w_proto || (w_nwe_rise && (r_state != IDLE));
    w_to_set   = (r_state == READ_WAIT) && !w_abort && !bus.Rd_Ack &&
                 (r_cnt == CNT_W'(RD_TIMEOUT - 1));
  end

  always_ff @(posedge FPGA_Clock) begin
    if (FPGA_Reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      bus.Wr_Strobe   <= 1'b0;
      bus.Wr_Addr     <= '0;
      bus.Wr_Data     <= '0;
      bus.Rd_Req      <= 1'b0;
      bus.Rd_Addr     <= '0;
      bus.CPU_Rd_Data <= '0;
      bus.Data_OE     <= 1'b0;
      bus.Err_Timeout <= 1'b0;
      bus.Err_Proto   <= 1'b0;
    end else begin
      bus.Wr_Strobe   <= w_wr_go;
      bus.Rd_Req      <= 1'b0;
      bus.Err_Proto   <= w_proto_set | (bus.Err_Proto & ~bus.Err_Clr);
      bus.Err_Timeout <= w_to_set | (bus.Err_Timeout & ~bus.Err_Clr);
      if (w_wr_go) begin
        bus.Wr_Addr <= r_addr_dl[SYNC_STAGES];
        bus.Wr_Data <= r_data_dl[SYNC_STAGES];
      end
      case (r_state)
        IDLE: begin
          if (w_rd_go) begin
            bus.Rd_Req  <= 1'b1;
            bus.Rd_Addr <= r_addr_dl[SYNC_STAGES];
            r_cnt       <= '0;
            r_state     <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else if (bus.Rd_Ack) begin
            bus.CPU_Rd_Data <= bus.Rd_Data;
            bus.Data_OE     <= 1'b1;
            r_state         <= READ_HOLD;
          end else if (w_to_set) begin
            bus.CPU_Rd_Data <= TIMEOUT_DATA;
            bus.Data_OE     <= 1'b1;
            r_state         <= READ_HOLD;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        READ_HOLD: begin
          if (w_abort) begin
            bus.Data_OE <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          bus.Data_OE <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpu_bus_bridge : scoreboard bench for cpu_bus_bridge               |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_cpu_bus_bridge;
  localparam int DW = 16;
  localparam int AW = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [AW+DW-1:0] wr_q[$];
  logic [AW+DW-1:0] wr_dec_q[$];
  logic [AW-1:0]    rd_q[$];
  logic [DW-1:0]    dat_q[$];
  logic             prev_oe = 1'b0;

  always #5 clk = ~clk;

  cpu_bus_bridge_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  cpu_bus_bridge_if #(.DATA_W(DW), .ADDR_W(AW)) bus_dec ();

  assign bus_dec.CPU_NCS  = bus.CPU_NCS;
  assign bus_dec.CPU_NWE  = bus.CPU_NWE;
  assign bus_dec.CPU_NRD  = bus.CPU_NRD;
  assign bus_dec.CPU_Data = bus.CPU_Data;
  assign bus_dec.CPU_Addr = bus.CPU_Addr;
  assign bus_dec.Rd_Ack   = bus.Rd_Ack;
  assign bus_dec.Rd_Data  = bus.Rd_Data;
  assign bus_dec.Err_Clr  = bus.Err_Clr;

  cpu_bus_bridge #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .FPGA_Clock(clk), .FPGA_Reset(rst), .bus(bus)
  );

  cpu_bus_bridge #(
    .DATA_W(DW), .ADDR_W(AW),
    .BASE_ADDR(26'h1000000), .ADDR_MASK(26'h3000000)
  ) dut_dec (
    .FPGA_Clock(clk), .FPGA_Reset(rst), .bus(bus_dec)
  );

  // Scoreboard monitors
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (bus.Wr_Strobe === 1'b1) begin
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected got addr=%h data=%h want no strobe", bus.Wr_Addr, bus.Wr_Data);
      end else begin
        e = wr_q.pop_front();
        if ({bus.Wr_Addr, bus.Wr_Data} !== e) begin
          n_fail++;
          $display("FAIL wr_value got addr=%h data=%h want addr=%h data=%h",
                   bus.Wr_Addr, bus.Wr_Data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (bus_dec.Wr_Strobe === 1'b1) begin
      n_cmp++;
      if (wr_dec_q.size() == 0) begin
        n_fail++;
        $display("FAIL dec_wr_unexpected got addr=%h want no strobe", bus_dec.Wr_Addr);
      end else begin
        e = wr_dec_q.pop_front();
        if ({bus_dec.Wr_Addr, bus_dec.Wr_Data} !== e) begin
          n_fail++;
          $display("FAIL dec_wr_value got %h want %h", {bus_dec.Wr_Addr, bus_dec.Wr_Data}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [AW-1:0] e;
    if (bus.Rd_Req === 1'b1) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_req_unexpected got addr=%h want no request", bus.Rd_Addr);
      end else begin
        e = rd_q.pop_front();
        if (bus.Rd_Addr !== e) begin
          n_fail++;
          $display("FAIL rd_addr got %h want %h", bus.Rd_Addr, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (bus.Data_OE === 1'b1 && prev_oe === 1'b0) begin
      n_cmp++;
      if (dat_q.size() == 0) begin
        n_fail++;
        $display("FAIL oe_unexpected got data=%h want Data_OE low", bus.CPU_Rd_Data);
      end else begin
        e = dat_q.pop_front();
        if (bus.CPU_Rd_Data !== e) begin
          n_fail++;
          $display("FAIL rd_data got %h want %h", bus.CPU_Rd_Data, e);
        end
      end
    end
    prev_oe = bus.Data_OE;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    bus.CPU_NCS = 1'b1; bus.CPU_NWE = 1'b1; bus.CPU_NRD = 1'b1;
    bus.CPU_Addr = '0;  bus.CPU_Data = '0;
    bus.Rd_Ack = 1'b0;  bus.Rd_Data = '0;  bus.Err_Clr = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if ({bus.Wr_Strobe, bus.Rd_Req, bus.Data_OE, bus.Err_Timeout, bus.Err_Proto} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 00000",
               {bus.Wr_Strobe, bus.Rd_Req, bus.Data_OE, bus.Err_Timeout, bus.Err_Proto});
    end
    n_cmp++;
    if ({bus.Wr_Addr, bus.Wr_Data, bus.Rd_Addr, bus.CPU_Rd_Data} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs got %h/%h/%h/%h want all zero",
               bus.Wr_Addr, bus.Wr_Data, bus.Rd_Addr, bus.CPU_Rd_Data);
    end
    rst = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    n_cmp++;
    if ({bus.Wr_Strobe, bus.Rd_Req, bus.Data_OE, bus.Err_Proto} !== 4'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got %b want 0000",
               {bus.Wr_Strobe, bus.Rd_Req, bus.Data_OE, bus.Err_Proto});
    end
  endtask

  task automatic test_write;
    int first = -1;
    int cnt = 0;
    tick();
    bus.CPU_NCS = 1'b0; bus.CPU_Addr = 26'h0000123; bus.CPU_Data = 16'hA5A5;
    tick();
    bus.CPU_NWE = 1'b0;
    repeat (6) tick();
    wr_q.push_back({26'h0000123, 16'hA5A5});
    bus.CPU_NWE = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (bus.Wr_Strobe === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    n_cmp++;
    if (first != 2) begin
      n_fail++;
      $display("FAIL wr_latency got edge %0d want edge 2", first);
    end
    n_cmp++;
    if (cnt != 1) begin
      n_fail++;
      $display("FAIL wr_pulse_count got %0d want 1", cnt);
    end
    bus.CPU_NCS = 1'b1; bus.CPU_Addr = 26'h3FFFFFF; bus.CPU_Data = 16'h0000;
    repeat (4) cyc();
    n_cmp++;
    if ({bus.Wr_Addr, bus.Wr_Data} !== {26'h0000123, 16'hA5A5}) begin
      n_fail++;
      $display("FAIL wr_hold got %h/%h want 0000123/a5a5", bus.Wr_Addr, bus.Wr_Data);
    end
  endtask

  task automatic test_read_ack;
    bit found = 0;
    bit stayed = 1;
    bit dropped = 0;
    tick();
    bus.CPU_Addr = 26'h0000456; bus.CPU_NCS = 1'b0;
    tick();
    rd_q.push_back(26'h0000456);
    bus.CPU_NRD = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      cyc();
      if (bus.Rd_Req === 1'b1) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL rd_req_seen got none want pulse within 10 cycles");
    end
    cyc();
    cyc();
    n_cmp++;
    if (bus.Data_OE !== 1'b0) begin
      n_fail++;
      $display("FAIL oe_before_ack got %b want 0", bus.Data_OE);
    end
    bus.Rd_Ack = 1'b1; bus.Rd_Data = 16'h1234;
    dat_q.push_back(16'h1234);
    @(posedge clk);
    #1 bus.Rd_Ack = 1'b0; bus.Rd_Data = 16'h0000;
    @(negedge clk);
    n_cmp++;
    if ({bus.Data_OE, bus.Err_Timeout} !== 2'b10) begin
      n_fail++;
      $display("FAIL ack_oe got oe=%b to=%b want oe=1 to=0", bus.Data_OE, bus.Err_Timeout);
    end
    repeat (4) begin
      cyc();
      if (bus.Data_OE !== 1'b1) stayed = 0;
    end
    n_cmp++;
    if (!stayed) begin
      n_fail++;
      $display("FAIL oe_hold got dropped want held while NRD low");
    end
    bus.CPU_NRD = 1'b1;
    for (int t = 0; t < 6 && !dropped; t++) begin
      cyc();
      if (bus.Data_OE === 1'b0) dropped = 1;
    end
    n_cmp++;
    if (!dropped) begin
      n_fail++;
      $display("FAIL oe_release got 1 want 0 after NRD high");
    end
    bus.CPU_NCS = 1'b1;
  endtask

  task automatic test_timeout;
    int req_k = -1;
    int oe_k = -1;
    logic to_at_oe = 1'bx;
    logic to_before = 1'bx;
    logic to_last = 1'bx;
    tick();
    bus.CPU_Addr = 26'h0000789; bus.CPU_NCS = 1'b0;
    tick();
    rd_q.push_back(26'h0000789);
    dat_q.push_back(16'hDEAD);
    bus.CPU_NRD = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (bus.Rd_Req === 1'b1 && req_k < 0) req_k = k;
      if (bus.Data_OE === 1'b1 && oe_k < 0) begin
        oe_k = k;
        to_at_oe = bus.Err_Timeout;
        to_before = to_last;
      end
      to_last = bus.Err_Timeout;
    end
    n_cmp++;
    if (req_k < 0 || oe_k - req_k != 15) begin
      n_fail++;
      $display("FAIL timeout_latency got req@%0d oe@%0d want oe 15 cycles after req", req_k, oe_k);
    end
    n_cmp++;
    if ({to_before, to_at_oe} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_flag got before=%b at=%b want 0 then 1", to_before, to_at_oe);
    end
    bus.CPU_NRD = 1'b1; bus.CPU_NCS = 1'b1;
    repeat (5) cyc();
    n_cmp++;
    if ({bus.Data_OE, bus.Err_Timeout} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_sticky got oe=%b to=%b want oe=0 to=1", bus.Data_OE, bus.Err_Timeout);
    end
    bus.Err_Clr = 1'b1;
    @(posedge clk);
    #1 bus.Err_Clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.Err_Timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear got %b want 0", bus.Err_Timeout);
    end
  endtask

  task automatic test_abort;
    bit oe_seen = 0;
    tick();
    bus.CPU_Addr = 26'h0000ABC; bus.CPU_NCS = 1'b0;
    tick();
    rd_q.push_back(26'h0000ABC);
    bus.CPU_NRD = 1'b0;
    repeat (4) tick();
    bus.CPU_NRD = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (bus.Data_OE === 1'b1) oe_seen = 1;
      if (k == 6) begin
        bus.Rd_Ack = 1'b1; bus.Rd_Data = 16'hBEEF;
      end else begin
        bus.Rd_Ack = 1'b0; bus.Rd_Data = 16'h0000;
      end
    end
    n_cmp++;
    if (oe_seen) begin
      n_fail++;
      $display("FAIL abort_oe got Data_OE=1 want never 1");
    end
    n_cmp++;
    if ({bus.CPU_Rd_Data, bus.Err_Timeout} !== {16'hDEAD, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_data got %h to=%b want dead to=0", bus.CPU_Rd_Data, bus.Err_Timeout);
    end
    bus.CPU_NCS = 1'b1;
  endtask

  task automatic test_decode;
    logic [AW-1:0] addrs [2];
    logic [DW-1:0] datas [2];
    int dec_cnt;
    addrs[0] = 26'h2000010; datas[0] = 16'h0F0F;
    addrs[1] = 26'h1000010; datas[1] = 16'hF0F0;
    for (int i = 0; i < 2; i++) begin
      dec_cnt = 0;
      tick();
      bus.CPU_NCS = 1'b0; bus.CPU_Addr = addrs[i]; bus.CPU_Data = datas[i];
      tick();
      bus.CPU_NWE = 1'b0;
      repeat (3) tick();
      wr_q.push_back({addrs[i], datas[i]});
      if (i == 1) wr_dec_q.push_back({addrs[i], datas[i]});
      bus.CPU_NWE = 1'b1;
      repeat (5) begin
        cyc();
        if (bus_dec.Wr_Strobe === 1'b1) dec_cnt++;
      end
      n_cmp++;
      if (dec_cnt != i) begin
        n_fail++;
        $display("FAIL decode_%0h got %0d strobes want %0d", addrs[i], dec_cnt, i);
      end
      bus.CPU_NCS = 1'b1;
    end
  endtask

  task automatic test_proto;
    int ev = 0;
    tick();
    bus.CPU_Addr = 26'h0000321; bus.CPU_NCS = 1'b0;
    tick();
    bus.CPU_NWE = 1'b0; bus.CPU_NRD = 1'b0;
    repeat (5) begin
      cyc();
      if (bus.Wr_Strobe === 1'b1 || bus.Rd_Req === 1'b1) ev++;
    end
    n_cmp++;
    if (bus.Err_Proto !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_set got %b want 1", bus.Err_Proto);
    end
    bus.Err_Clr = 1'b1;
    @(posedge clk);
    #1 bus.Err_Clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.Err_Proto !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_set_priority got %b want 1", bus.Err_Proto);
    end
    bus.CPU_NWE = 1'b1; bus.CPU_NRD = 1'b1;
    repeat (6) begin
      cyc();
      if (bus.Wr_Strobe === 1'b1 || bus.Rd_Req === 1'b1) ev++;
    end
    n_cmp++;
    if (ev != 0) begin
      n_fail++;
      $display("FAIL proto_no_strobe got %0d strobes want 0", ev);
    end
    bus.CPU_NCS = 1'b1;
    bus.Err_Clr = 1'b1;
    @(posedge clk);
    #1 bus.Err_Clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.Err_Proto !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_clear got %b want 0", bus.Err_Proto);
    end
  endtask

  task automatic test_reset_mid_read;
    bit found = 0;
    int ev = 0;
    tick();
    bus.CPU_Addr = 26'h0000555; bus.CPU_NCS = 1'b0;
    tick();
    rd_q.push_back(26'h0000555);
    dat_q.push_back(16'h5A5A);
    bus.CPU_NRD = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      cyc();
      if (bus.Rd_Req === 1'b1) found = 1;
    end
    bus.Rd_Ack = 1'b1; bus.Rd_Data = 16'h5A5A;
    @(posedge clk);
    #1 bus.Rd_Ack = 1'b0; bus.Rd_Data = 16'h0000;
    @(negedge clk);
    n_cmp++;
    if (bus.Data_OE !== 1'b1) begin
      n_fail++;
      $display("FAIL midread_oe got %b want 1", bus.Data_OE);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.Data_OE, bus.CPU_Rd_Data} !== {1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL midread_reset got oe=%b data=%h want oe=0 data=0000", bus.Data_OE, bus.CPU_Rd_Data);
    end
    repeat (10) begin
      cyc();
      if (bus.Rd_Req === 1'b1 || bus.Data_OE === 1'b1) ev++;
    end
    n_cmp++;
    if (ev != 0) begin
      n_fail++;
      $display("FAIL midread_span got %0d events want 0", ev);
    end
    bus.CPU_NRD = 1'b1; bus.CPU_NCS = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_ack();
    test_timeout();
    test_abort();
    test_decode();
    test_proto();
    test_reset_mid_read();
    repeat (3) cyc();
    n_cmp++;
    if (wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL wr_queue_left got %0d want 0", wr_q.size());
    end
    n_cmp++;
    if (wr_dec_q.size() != 0) begin
      n_fail++;
      $display("FAIL dec_queue_left got %0d want 0", wr_dec_q.size());
    end
    n_cmp++;
    if (rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_queue_left got %0d want 0", rd_q.size());
    end
    n_cmp++;
    if (dat_q.size() != 0) begin
      n_fail++;
      $display("FAIL data_queue_left got %0d want 0", dat_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
